perf_monitor: RTL

Per-cycle performance and run-control monitor inside `CPU`, directly downstream of the hazard detector, the IF stage flush logic and the WB stage. It counts cycles, stalls, flushes and retired instructions, and detects program completion or timeout. It gives the bench one registered read port and two status flags, so the bench no longer counts these events itself.

---
 rtl/perf_monitor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/perf_monitor.sv
// Run-control and event counter block for the CPU pipeline: cycles, stalls, flushes, retires, bubble streak.
// Define PERF_MONITOR_SAT_EN to make every counter saturate at all-ones instead of wrapping.
//
// state | meaning
// IDLE  | not running, counters hold
// RUN   | counting one set of events per edge
// DONE  | halt or timeout seen, counters frozen until clear or start drops
module perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int HALT_NOPS  = 5,
    parameter int MAX_CYCLES = 70
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             retire_i,
    input  logic [2:0]       sel_i,
    output logic [CNT_W-1:0] data_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, stl_q, fls_q, ret_q, streak_q;
    logic [CNT_W-1:0] streak_inc, rd_mux;
    logic             seen_q;
    logic             count_en, streak_en, halt, tmo;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
`ifdef PERF_MONITOR_SAT_EN
        if (en && (v != '1))
            return v + CNT_W'(1);
        return v;
`else
        return en ? v + CNT_W'(1) : v;
`endif
    endfunction

    // Clear wins over everything, so it also masks the halt/timeout checks.
    assign count_en   = start_i && (state_q != DONE) && !clear_i;
    assign streak_en  = count_en && !retire_i && (seen_q || (ret_q != '0));
    assign streak_inc = bump(streak_q, 1'b1);
    assign halt       = streak_en && (64'(streak_inc) >= 64'(HALT_NOPS));
    assign tmo        = count_en && (MAX_CYCLES != 0) &&
                        (64'(cyc_q) == 64'(MAX_CYCLES) - 64'd1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = start_i ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_i) state_d = (halt || tmo) ? DONE : RUN;
                RUN: begin
                    if (!start_i)
                        state_d = IDLE;
                    else if (halt || tmo)
                        state_d = DONE;
                end
                DONE: if (!start_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        state_o = state_q;
        case (sel_i)
            3'd0:    rd_mux = cyc_q;
            3'd1:    rd_mux = stl_q;
            3'd2:    rd_mux = fls_q;
            3'd3:    rd_mux = ret_q;
            3'd4:    rd_mux = streak_q;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q     <= '0;
            stl_q     <= '0;
            fls_q     <= '0;
            ret_q     <= '0;
            streak_q  <= '0;
            seen_q    <= 1'b0;
            data_o    <= '0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            data_o <= rd_mux;
            if (clear_i) begin
                cyc_q     <= '0;
                stl_q     <= '0;
                fls_q     <= '0;
                ret_q     <= '0;
                streak_q  <= '0;
                seen_q    <= 1'b0;
                done_o    <= 1'b0;
                timeout_o <= 1'b0;
            end else if (count_en) begin
                cyc_q <= bump(cyc_q, 1'b1);
                stl_q <= bump(stl_q, stall_i);
                fls_q <= bump(fls_q, flush_i);
                ret_q <= bump(ret_q, retire_i);
                if (retire_i) begin
                    streak_q <= '0;
                    seen_q   <= 1'b1;
                end else if (streak_en) begin
                    streak_q <= streak_inc;
                end
                if (halt) begin
                    done_o    <= 1'b1;
                    timeout_o <= 1'b0;
                end else if (tmo) begin
                    done_o    <= 1'b1;
                    timeout_o <= 1'b1;
                end
            end
        end
    end

endmodule
